// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader and the Memblock it programs.
package imem_pkg;

   // Memblock geometry used by the loader and its benches.
   localparam int MEM_WIDTH      = 32;
   localparam int MEM_DEPTH      = 128;
   localparam int MEM_ADDR_W     = $clog2(MEM_DEPTH);
   localparam int BYTES_PER_WORD = 4;

   // Loader sequence: gather bytes, write a word, read the image back, check, finish.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_WRITE   = 3'd2,
      ST_VRD     = 3'd3,
      ST_VCHK    = 3'd4,
      ST_FIN     = 3'd5
   } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles a little-endian word from a byte stream; the first byte lands in the LSB.
// Handshake: a byte moves when s_valid && s_ready. s_ready follows enable, and
// word_valid pulses in the same cycle that the final byte of a word is accepted.
module byte_packer
   import imem_pkg::*;
#(
   parameter int WIDTH = MEM_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic             s_valid,
   input  logic [7:0]       s_data,
   output logic             s_ready,
   output logic             word_valid,
   output logic [WIDTH-1:0] word_data
);

   localparam int CNT_W = $clog2(BYTES_PER_WORD);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] merged;
   logic             accept;

   // Place each accepted byte at its lane and release the word on the final byte.
   always_comb begin
      s_ready    = enable;
      accept     = enable && s_valid;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      word_valid = 1'b0;
      merged     = acc_q;
      merged[{cnt_q, 3'b000} +: 8] = s_data;
      word_data  = merged;
      if (clear) begin
         cnt_d = '0;
         acc_d = '0;
      end else if (accept) begin
         if (cnt_q == CNT_W'(BYTES_PER_WORD - 1)) begin
            word_valid = 1'b1;
            cnt_d      = '0;
            acc_d      = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
            acc_d = merged;
         end
      end
   end

   // Byte counter and partial word; reset discards any half-built word.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         acc_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory, then reads the image back and compares
// XOR checksums of written and read data. Addresses wrap modulo DEPTH, which
// relies on DEPTH being a power of two (ADDR_W = clog2(DEPTH)).
module imem_loader
   import imem_pkg::*;
#(
   parameter int WIDTH  = MEM_WIDTH,
   parameter int DEPTH  = MEM_DEPTH,
   parameter int ADDR_W = MEM_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   word_count,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   output logic              s_ready,
   output logic              we0,
   output logic [ADDR_W-1:0] wr_addr0,
   output logic [WIDTH-1:0]  wr_din0,
   output logic [ADDR_W-1:0] rd_addr0,
   input  logic [WIDTH-1:0]  rd_dout0,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_written
);

   localparam int CNT_W = ADDR_W + 1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [CNT_W-1:0]  words_written_q, words_written_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [WIDTH-1:0]  wr_din_q, wr_din_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
   logic              rd_fold_q, rd_fold_d;
   logic [WIDTH-1:0]  wr_sum_q, wr_sum_d;
   logic [WIDTH-1:0]  rd_sum_q, rd_sum_d;
   logic              error_q, error_d;

   logic              start_accept;
   logic              word_valid;
   logic [WIDTH-1:0]  word_data;

   assign start_accept = (state_q == ST_IDLE) && start;

   byte_packer #(
      .WIDTH (WIDTH)
   ) u_packer (
      .clk        (clk),
      .rst        (rst),
      .clear      (start_accept),
      .enable     (state_q == ST_COLLECT),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .s_ready    (s_ready),
      .word_valid (word_valid),
      .word_data  (word_data)
   );

   // Outputs decode straight from flops so they carry no combinational input paths.
   assign we0           = (state_q == ST_WRITE);
   assign busy          = (state_q != ST_IDLE) && (state_q != ST_FIN);
   assign done          = (state_q == ST_FIN);
   assign error         = error_q;
   assign wr_addr0      = wr_addr_q;
   assign wr_din0       = wr_din_q;
   assign rd_addr0      = rd_addr_q;
   assign words_written = words_written_q;

   // Sequencer: next state plus the address, count and checksum updates of each phase.
   always_comb begin
      state_d         = state_q;
      base_d          = base_q;
      count_d         = count_q;
      words_written_d = words_written_q;
      wr_addr_d       = wr_addr_q;
      wr_din_d        = wr_din_q;
      rd_addr_d       = rd_addr_q;
      rd_cnt_d        = rd_cnt_q;
      wr_sum_d        = wr_sum_q;
      error_d         = error_q;
      // Read data for an address issued in VRD shows up one cycle later.
      rd_fold_d       = (state_q == ST_VRD);
      rd_sum_d        = rd_fold_q ? (rd_sum_q ^ rd_dout0) : rd_sum_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               base_d          = base_addr;
               count_d         = (word_count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : word_count;
               error_d         = 1'b0;
               words_written_d = '0;
               wr_sum_d        = '0;
               rd_sum_d        = '0;
               state_d         = (word_count == '0) ? ST_FIN : ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            if (word_valid) begin
               wr_addr_d = base_q + words_written_q[ADDR_W-1:0];
               wr_din_d  = word_data;
               state_d   = ST_WRITE;
            end
         end
         ST_WRITE: begin
            wr_sum_d        = wr_sum_q ^ wr_din_q;
            words_written_d = words_written_q + CNT_W'(1);
            if ((words_written_q + CNT_W'(1)) < count_q) begin
               state_d = ST_COLLECT;
            end else begin
               rd_addr_d = base_q;
               rd_cnt_d  = '0;
               state_d   = ST_VRD;
            end
         end
         ST_VRD: begin
            if ((rd_cnt_q + CNT_W'(1)) == count_q) begin
               state_d = ST_VCHK;
            end else begin
               rd_addr_d = rd_addr_q + ADDR_W'(1);
               rd_cnt_d  = rd_cnt_q + CNT_W'(1);
            end
         end
         ST_VCHK: begin
            if ((rd_sum_q ^ rd_dout0) != wr_sum_q) begin
               error_d = 1'b1;
            end
            state_d = ST_FIN;
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         base_q          <= '0;
         count_q         <= '0;
         words_written_q <= '0;
         wr_addr_q       <= '0;
         wr_din_q        <= '0;
         rd_addr_q       <= '0;
         rd_cnt_q        <= '0;
         rd_fold_q       <= 1'b0;
         wr_sum_q        <= '0;
         rd_sum_q        <= '0;
         error_q         <= 1'b0;
      end else begin
         state_q         <= state_d;
         base_q          <= base_d;
         count_q         <= count_d;
         words_written_q <= words_written_d;
         wr_addr_q       <= wr_addr_d;
         wr_din_q        <= wr_din_d;
         rd_addr_q       <= rd_addr_d;
         rd_cnt_q        <= rd_cnt_d;
         rd_fold_q       <= rd_fold_d;
         wr_sum_q        <= wr_sum_d;
         rd_sum_q        <= rd_sum_d;
         error_q         <= error_d;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader with a behavioural Memblock (registered read) attached.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [6:0]  base_addr = '0;
   logic [7:0]  word_count = '0;
   logic        s_valid = 1'b0;
   logic [7:0]  s_data = '0;
   logic        s_ready;
   logic        we0;
   logic [6:0]  wr_addr0;
   logic [31:0] wr_din0;
   logic [6:0]  rd_addr0;
   logic [31:0] rd_dout0;
   logic        busy;
   logic        done;
   logic        error;
   logic [7:0]  words_written;

   logic [31:0] mem [128];
   logic [31:0] mem_q = '0;
   logic        corrupt = 1'b0;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          start_cyc = 0;
   int          we_cnt = 0;
   logic [38:0] exp_q[$];
   logic [38:0] exp_e;

   imem_loader dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .base_addr     (base_addr),
      .word_count    (word_count),
      .s_valid       (s_valid),
      .s_data        (s_data),
      .s_ready       (s_ready),
      .we0           (we0),
      .wr_addr0      (wr_addr0),
      .wr_din0       (wr_din0),
      .rd_addr0      (rd_addr0),
      .rd_dout0      (rd_dout0),
      .busy          (busy),
      .done          (done),
      .error         (error),
      .words_written (words_written)
   );

   // Clock and cycle counter.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: write port plus registered read, with optional bit-0 corruption.
   always @(posedge clk) begin
      if (we0) mem[wr_addr0] <= wr_din0;
      mem_q <= mem[rd_addr0];
   end
   assign rd_dout0 = mem_q ^ {31'b0, corrupt};

   // Scoreboard: every write must match the next expected {addr,data}; s_ready low while writing.
   always @(negedge clk) begin
      if (we0 === 1'b1) begin
         we_cnt++;
         checks++;
         if (s_ready !== 1'b0) begin
            failures++;
            $display("FAIL write_s_ready actual=%b required=0", s_ready);
         end
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write addr=%0d data=%h", wr_addr0, wr_din0);
         end else begin
            exp_e = exp_q.pop_front();
            if ({wr_addr0, wr_din0} !== exp_e) begin
               failures++;
               $display("FAIL write_word actual=%0d:%h required=%0d:%h",
                        wr_addr0, wr_din0, exp_e[38:32], exp_e[31:0]);
            end
         end
      end
   end

   task automatic start_load(input logic [6:0] b, input logic [7:0] n);
      @(posedge clk); #1;
      start = 1'b1; base_addr = b; word_count = n;
      @(negedge clk);
      start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit ok = 1'b0;
      s_valid = 1'b1; s_data = b;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = s_ready;
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      if (!ok) begin
         checks++; failures++;
         $display("FAIL byte_accept timeout byte=%h", b);
      end
   endtask

   task automatic send_word(input logic [31:0] w, input logic [6:0] a, input bit stall);
      exp_q.push_back({a, w});
      for (int k = 0; k < 4; k++) begin
         send_byte(w[8*k +: 8]);
         if (stall) begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic wait_done(output int lat);
      bit ok = 1'b0;
      lat = -1;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clk);
         if (done === 1'b1) ok = 1'b1;
      end
      if (!ok) begin
         checks++; failures++;
         $display("FAIL done_timeout actual=no_done required=done");
      end else begin
         lat = cyc - start_cyc;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({s_ready, we0, wr_addr0, wr_din0, rd_addr0, busy, done, error, words_written} !== '0) begin
         failures++;
         $display("FAIL reset_values actual=%b%b %0d %h %0d %b%b%b %0d required=all_zero",
                  s_ready, we0, wr_addr0, wr_din0, rd_addr0, busy, done, error, words_written);
      end
   endtask

   task automatic test_basic();
      int lat;
      start_load(7'd0, 8'd3);
      send_word(32'h12345678, 7'd0, 1'b0);
      send_word(32'hDEADBEEF, 7'd1, 1'b0);
      send_word(32'h00000001, 7'd2, 1'b0);
      wait_done(lat);
      checks++;
      if (lat !== 20) begin failures++; $display("FAIL basic_latency actual=%0d required=20", lat); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done actual=%b required=0", busy); end
      checks++;
      if (error !== 1'b0) begin failures++; $display("FAIL basic_error actual=%b required=0", error); end
      checks++;
      if (words_written !== 8'd3) begin failures++; $display("FAIL basic_words actual=%0d required=3", words_written); end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse actual=%b required=0", done); end
      checks++;
      if ({mem[0], mem[1], mem[2]} !== {32'h12345678, 32'hDEADBEEF, 32'h00000001}) begin
         failures++;
         $display("FAIL basic_mem actual=%h %h %h required=12345678 deadbeef 00000001", mem[0], mem[1], mem[2]);
      end
   endtask

   task automatic test_wrap();
      int lat;
      logic [31:0] w [4];
      start_load(7'd126, 8'd4);
      for (int i = 0; i < 4; i++) begin
         w[i] = $urandom_range(32'hFFFF_FFFF, 0);
         send_word(w[i], 7'(126 + i), 1'b0);
      end
      wait_done(lat);
      checks++;
      if (lat !== 26) begin failures++; $display("FAIL wrap_latency actual=%0d required=26", lat); end
      checks++;
      if (error !== 1'b0) begin failures++; $display("FAIL wrap_error actual=%b required=0", error); end
      checks++;
      if ({mem[126], mem[127], mem[0], mem[1]} !== {w[0], w[1], w[2], w[3]}) begin
         failures++;
         $display("FAIL wrap_mem actual=%h %h %h %h required=%h %h %h %h",
                  mem[126], mem[127], mem[0], mem[1], w[0], w[1], w[2], w[3]);
      end
   endtask

   task automatic test_stall();
      int lat;
      start_load(7'd40, 8'd3);
      send_word(32'h12345678, 7'd40, 1'b1);
      send_word(32'hDEADBEEF, 7'd41, 1'b1);
      send_word(32'h00000001, 7'd42, 1'b1);
      wait_done(lat);
      checks++;
      if (error !== 1'b0 || words_written !== 8'd3) begin
         failures++;
         $display("FAIL stall_status actual=err%b words%0d required=err0 words3", error, words_written);
      end
      checks++;
      if ({mem[40], mem[41], mem[42]} !== {32'h12345678, 32'hDEADBEEF, 32'h00000001}) begin
         failures++;
         $display("FAIL stall_mem actual=%h %h %h required=12345678 deadbeef 00000001", mem[40], mem[41], mem[42]);
      end
   endtask

   task automatic test_corrupt();
      int lat;
      start_load(7'd30, 8'd1);
      send_word(32'hCAFEF00D, 7'd30, 1'b0);
      // Now in the write cycle; next is the read issue, then the check cycle with data.
      @(posedge clk); #1;
      @(posedge clk); #1 corrupt = 1'b1;
      @(posedge clk); #1 corrupt = 1'b0;
      wait_done(lat);
      checks++;
      if (error !== 1'b1) begin failures++; $display("FAIL corrupt_error_at_done actual=%b required=1", error); end
      repeat (3) @(negedge clk);
      checks++;
      if (error !== 1'b1) begin failures++; $display("FAIL corrupt_error_sticky actual=%b required=1", error); end
      start_load(7'd0, 8'd0);
      wait_done(lat);
      checks++;
      if (error !== 1'b0) begin failures++; $display("FAIL corrupt_error_cleared actual=%b required=0", error); end
   endtask

   task automatic test_zero_and_ignored_start();
      int lat;
      int we_before;
      we_before = we_cnt;
      start_load(7'd9, 8'd0);
      wait_done(lat);
      checks++;
      if (lat !== 1) begin failures++; $display("FAIL zero_latency actual=%0d required=1", lat); end
      checks++;
      if (we_cnt !== we_before || words_written !== 8'd0) begin
         failures++;
         $display("FAIL zero_no_write actual=writes%0d words%0d required=writes0 words0", we_cnt - we_before, words_written);
      end
      start_load(7'd10, 8'd2);
      send_word(32'hA5A55A5A, 7'd10, 1'b0);
      @(posedge clk); #1 start = 1'b1; base_addr = 7'd50; word_count = 8'd5;
      @(posedge clk); #1 start = 1'b0;
      send_word(32'h0BADC0DE, 7'd11, 1'b0);
      wait_done(lat);
      checks++;
      if (words_written !== 8'd2 || error !== 1'b0) begin
         failures++;
         $display("FAIL ignored_start actual=words%0d err%b required=words2 err0", words_written, error);
      end
      checks++;
      if ({mem[10], mem[11]} !== {32'hA5A55A5A, 32'h0BADC0DE}) begin
         failures++;
         $display("FAIL ignored_start_mem actual=%h %h required=a5a55a5a 0badc0de", mem[10], mem[11]);
      end
   endtask

   task automatic test_reset_mid_load();
      int lat;
      start_load(7'd20, 8'd2);
      send_word(32'h11223344, 7'd20, 1'b0);
      send_byte(8'h99);
      send_byte(8'h88);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({s_ready, we0, wr_addr0, wr_din0, rd_addr0, busy, done, error, words_written} !== '0) begin
         failures++;
         $display("FAIL midreset_values actual=%b%b %0d %h %0d %b%b%b %0d required=all_zero",
                  s_ready, we0, wr_addr0, wr_din0, rd_addr0, busy, done, error, words_written);
      end
      start_load(7'd5, 8'd1);
      send_word(32'h55667788, 7'd5, 1'b0);
      wait_done(lat);
      checks++;
      if (mem[5] !== 32'h55667788 || words_written !== 8'd1 || error !== 1'b0) begin
         failures++;
         $display("FAIL midreset_reload actual=%h words%0d err%b required=55667788 words1 err0",
                  mem[5], words_written, error);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_stall();
      test_corrupt();
      test_zero_and_ignored_start();
      test_reset_mid_load();
      repeat (2) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL missing_writes actual=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
